// File: rtl/run_sequencer.sv
// run_sequencer: run-control FSM for the ARK core and sole owner of the DataRAM port.
// Holds the core in init while the host preloads DataRAM, releases it, counts executed
// cycles until halt or timeout, then hands DataRAM back to the host for readback.
module run_sequencer #(
    parameter int               ADDR_W      = 8,
    parameter int               DATA_W      = 8,
    parameter int               CNT_W       = 16,
    parameter int               INIT_CYCLES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Go,
    input  logic              HostReq,
    input  logic              HostWrite,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWData,
    output logic              HostGnt,
    output logic [DATA_W-1:0] HostRData,
    output logic              HostValid,
    input  logic [ADDR_W-1:0] CoreAddr,
    input  logic              CoreMemWrite,
    input  logic [DATA_W-1:0] CoreWData,
    input  logic              CoreHalt,
    output logic              CoreStart,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWrite,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic [1:0]        State,
    output logic [CNT_W-1:0]  InstCount,
    output logic              Timeout,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int                INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    state_t             state, state_next;
    logic               pending, pending_next;
    logic [INIT_W-1:0]  init_cnt, init_next;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   count_inc;
    logic               timeout_next;
    logic               host_rd;

    assign State     = state;
    assign count_inc = InstCount + CNT_W'(1);
    assign host_rd   = HostGnt & ~HostWrite;

    // Control state register: FSM state, pending run request, init timer, run counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            pending   <= 1'b0;
            init_cnt  <= '0;
            InstCount <= '0;
            Timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            init_cnt  <= init_next;
            InstCount <= count_next;
            Timeout   <= timeout_next;
        end
    end

    // Next-state logic plus the combinational DataRAM port mux and status outputs.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        init_next    = init_cnt;
        count_next   = InstCount;
        timeout_next = Timeout;
        HostGnt      = 1'b0;
        CoreStart    = 1'b1;
        Done         = 1'b0;
        MemAddr      = HostAddr;
        MemWData     = HostWData;
        MemWrite     = 1'b0;

        case (state)
            IDLE, DONE: begin
                HostGnt  = HostReq;
                MemWrite = HostReq & HostWrite;
                Done     = (state == DONE);
                // A Go arriving while the host is busy is remembered; the launch waits
                // for the first cycle without a host request.
                if ((pending || Go) && !HostReq) begin
                    state_next   = INIT;
                    pending_next = 1'b0;
                    init_next    = '0;
                    count_next   = '0;
                    timeout_next = 1'b0;
                end else if (Go) begin
                    pending_next = 1'b1;
                end
            end
            INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = RUN;
                end else begin
                    init_next = init_cnt + INIT_W'(1);
                end
            end
            RUN: begin
                CoreStart = 1'b0;
                MemAddr   = CoreAddr;
                MemWData  = CoreWData;
                MemWrite  = CoreMemWrite;
                // Halt takes priority over the timeout check and is not counted.
                if (CoreHalt) begin
                    state_next = DONE;
                end else begin
                    count_next = count_inc;
                    if (count_inc == TIMEOUT) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Host read-back register: captures DataRAM data one cycle after a granted read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HostRData <= '0;
            HostValid <= 1'b0;
        end else begin
            HostValid <= host_rd;
            if (host_rd) begin
                HostRData <= MemRData;
            end
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed plus randomized bench for run_sequencer with a DataRAM model
// and a behavioural expectation of run length, counters and memory contents.
module tb_run_sequencer;

    localparam int TIMEOUT     = 40;
    localparam int INIT_CYCLES = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        Go, HostReq, HostWrite;
    logic [7:0]  HostAddr, HostWData, HostRData;
    logic        HostGnt, HostValid;
    logic [7:0]  CoreAddr, CoreWData;
    logic        CoreMemWrite, CoreHalt, CoreStart;
    logic [7:0]  MemAddr, MemWData, MemRData;
    logic        MemWrite;
    logic [1:0]  State;
    logic [15:0] InstCount;
    logic        Timeout, Done;

    int errors = 0;
    int checks = 0;
    logic [7:0] ram     [256];
    logic [7:0] exp_ram [256];
    logic [7:0] last_core;
    logic       have_core;

    run_sequencer #(
        .ADDR_W(8), .DATA_W(8), .CNT_W(16), .INIT_CYCLES(INIT_CYCLES),
        .TIMEOUT(16'(TIMEOUT))
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .Go(Go),
        .HostReq(HostReq), .HostWrite(HostWrite), .HostAddr(HostAddr),
        .HostWData(HostWData), .HostGnt(HostGnt), .HostRData(HostRData),
        .HostValid(HostValid), .CoreAddr(CoreAddr), .CoreMemWrite(CoreMemWrite),
        .CoreWData(CoreWData), .CoreHalt(CoreHalt), .CoreStart(CoreStart),
        .MemAddr(MemAddr), .MemWrite(MemWrite), .MemWData(MemWData),
        .MemRData(MemRData), .State(State), .InstCount(InstCount),
        .Timeout(Timeout), .Done(Done)
    );

    always #5 CLK = ~CLK;

    // DataRAM: combinational read, write on the clock edge.
    assign MemRData = ram[MemAddr];
    always @(posedge CLK) if (MemWrite) ram[MemAddr] <= MemWData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        HostReq = 1'b1; HostWrite = 1'b1; HostAddr = a; HostWData = d;
        #1;
        chk("wr_gnt", 32'(HostGnt), 32'd1);
        chk("wr_memwrite", 32'(MemWrite), 32'd1);
        chk("wr_memaddr", 32'(MemAddr), 32'(a));
        tick();
        HostReq = 1'b0;
        exp_ram[a] = d;
    endtask

    task automatic host_read(input string tag, input logic [7:0] a);
        HostReq = 1'b1; HostWrite = 1'b0; HostAddr = a;
        #1;
        chk({tag, "_gnt"}, 32'(HostGnt), 32'd1);
        chk({tag, "_nowrite"}, 32'(MemWrite), 32'd0);
        tick();
        HostReq = 1'b0;
        chk({tag, "_valid"}, 32'(HostValid), 32'd1);
        chk({tag, "_data"}, 32'(HostRData), 32'(exp_ram[a]));
        tick();
        chk({tag, "_valid_drop"}, 32'(HostValid), 32'd0);
    endtask

    // Launch from IDLE/DONE with no host traffic; INIT follows on the next edge.
    task automatic go_pulse(input logic [1:0] from_state);
        Go = 1'b1; HostReq = 1'b0;
        #1;
        chk("go_from_state", 32'(State), 32'(from_state));
        tick();
        Go = 1'b0;
    endtask

    // h = number of unhalted RUN cycles before CoreHalt rises (h >= TIMEOUT: never halts).
    task automatic run_body(input int h);
        int k;
        bit fin;
        int exp_cnt;
        bit exp_to;
        exp_cnt = (h < TIMEOUT) ? h : TIMEOUT;
        exp_to  = (h >= TIMEOUT);
        for (int i = 0; i < INIT_CYCLES; i++) begin
            Go = (i == 0);
            HostReq = 1'b1; HostWrite = 1'b1; HostAddr = 8'h10; HostWData = 8'h00;
            #1;
            chk("init_state", 32'(State), 32'd1);
            chk("init_corestart", 32'(CoreStart), 32'd1);
            chk("init_gnt", 32'(HostGnt), 32'd0);
            chk("init_memwrite", 32'(MemWrite), 32'd0);
            chk("init_count", 32'(InstCount), 32'd0);
            chk("init_timeout", 32'(Timeout), 32'd0);
            tick();
        end
        Go = 1'b0; HostReq = 1'b0;
        k = 0;
        fin = 1'b0;
        while (!fin) begin
            CoreHalt = (k == h);
            if (k == 0) begin
                CoreMemWrite = 1'b1; CoreAddr = 8'h05; CoreWData = 8'h3C;
                HostReq = 1'b1; HostWrite = 1'b1; HostAddr = 8'h05; HostWData = 8'hFF;
            end else begin
                CoreMemWrite = 1'($urandom_range(0, 1));
                CoreAddr  = 8'h80 | 8'($urandom_range(0, 127));
                CoreWData = 8'($urandom);
                HostReq = 1'($urandom_range(0, 1)); HostWrite = 1'b1; HostAddr = 8'h10;
            end
            #1;
            chk("run_state", 32'(State), 32'd2);
            chk("run_corestart", 32'(CoreStart), 32'd0);
            chk("run_count", 32'(InstCount), 32'(k));
            chk("run_gnt", 32'(HostGnt), 32'd0);
            chk("run_memwrite", 32'(MemWrite), 32'(CoreMemWrite));
            chk("run_memaddr", 32'(MemAddr), 32'(CoreAddr));
            chk("run_memwdata", 32'(MemWData), 32'(CoreWData));
            if (CoreMemWrite) begin
                exp_ram[CoreAddr] = CoreWData;
                if (k != 0) begin last_core = CoreAddr; have_core = 1'b1; end
            end
            tick();
            if (k == h) fin = 1'b1;
            else begin
                k++;
                if (k == TIMEOUT) fin = 1'b1;
            end
        end
        CoreHalt = 1'b0; CoreMemWrite = 1'b0; HostReq = 1'b0;
        #1;
        chk("done_state", 32'(State), 32'd3);
        chk("done_flag", 32'(Done), 32'd1);
        chk("done_corestart", 32'(CoreStart), 32'd1);
        chk("done_count", 32'(InstCount), 32'(exp_cnt));
        chk("done_timeout", 32'(Timeout), 32'(exp_to));
        tick();
        chk("done_hold_state", 32'(State), 32'd3);
        chk("done_hold_count", 32'(InstCount), 32'(exp_cnt));
    endtask

    initial begin
        RST_N = 1'b0; Go = 1'b0; HostReq = 1'b0; HostWrite = 1'b0;
        HostAddr = 8'h00; HostWData = 8'h00; CoreAddr = 8'h00; CoreWData = 8'h00;
        CoreMemWrite = 1'b0; CoreHalt = 1'b0; have_core = 1'b0; last_core = 8'h00;
        #12;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_corestart", 32'(CoreStart), 32'd1);
        chk("rst_gnt", 32'(HostGnt), 32'd0);
        chk("rst_valid", 32'(HostValid), 32'd0);
        chk("rst_rdata", 32'(HostRData), 32'd0);
        chk("rst_count", 32'(InstCount), 32'd0);
        chk("rst_timeout", 32'(Timeout), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        RST_N = 1'b1;
        tick();

        // Host preload and readback in IDLE.
        host_write(8'h10, 8'hA5);
        host_read("rd_a5", 8'h10);

        // Core halts after 37 counted cycles; host blocked during RUN.
        go_pulse(2'd0);
        run_body(37);
        host_read("rd_core05", 8'h05);
        if (have_core) host_read("rd_core_rand", last_core);

        // Timeout, then halt coinciding with the timeout cycle.
        go_pulse(2'd3);
        run_body(TIMEOUT + 5);
        host_read("rd_a5_kept", 8'h10);
        go_pulse(2'd3);
        run_body(TIMEOUT - 1);
        go_pulse(2'd3);
        run_body(0);

        // Randomized run lengths.
        for (int r = 0; r < 3; r++) begin
            go_pulse(2'd3);
            run_body(int'($urandom_range(1, TIMEOUT + 3)));
        end

        // Go while host holds the port for 3 cycles: launch deferred until release.
        Go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            HostReq = 1'b1; HostWrite = 1'b1;
            HostAddr = 8'h20 + 8'(i); HostWData = 8'($urandom);
            #1;
            chk("defer_gnt", 32'(HostGnt), 32'd1);
            chk("defer_memwrite", 32'(MemWrite), 32'd1);
            exp_ram[HostAddr] = HostWData;
            tick();
            Go = 1'b0;
            chk("defer_state", 32'(State), 32'd3);
        end
        HostReq = 1'b0;
        #1;
        chk("defer_release_state", 32'(State), 32'd3);
        tick();
        run_body(int'($urandom_range(1, 20)));
        host_read("rd_defer", 8'h21);

        // Asynchronous reset in the middle of a run.
        go_pulse(2'd3);
        for (int i = 0; i < INIT_CYCLES + 9; i++) begin
            CoreMemWrite = (i >= INIT_CYCLES); CoreAddr = 8'h90; CoreWData = 8'h11;
            tick();
        end
        #1;
        chk("mid_count", 32'(InstCount), 32'd9);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_state", 32'(State), 32'd0);
        chk("arst_corestart", 32'(CoreStart), 32'd1);
        chk("arst_count", 32'(InstCount), 32'd0);
        chk("arst_memwrite", 32'(MemWrite), 32'd0);
        chk("arst_rdata", 32'(HostRData), 32'd0);
        chk("arst_done", 32'(Done), 32'd0);
        #2;
        RST_N = 1'b1;
        CoreMemWrite = 1'b0;
        tick();
        chk("arst_idle_hold", 32'(State), 32'd0);
        go_pulse(2'd0);
        run_body(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
